// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready request and result handshakes.
// Single-cycle ops produce their result on the accept edge. Multiply is a
// shift-add loop that retires one multiplier bit per cycle over WIDTH cycles.
module seq_alu #(
    parameter  int WIDTH   = 8,
    localparam int SHIFT_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [2:0]       unit_sel_in,
    input  logic             op_sel_in,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] src_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] alu_res_out,
    output logic [3:0]       flags_out
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_ext;
    logic [SHIFT_W-1:0] shamt;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c;
    logic               sc_v;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_last;

    assign accept = req_valid_in & req_ready_out;

    // State and datapath registers; reset clears everything, including a multiply in progress
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            res_q    <= '0;
            flags_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    // Single-cycle unit: subtract is acc + ~src + 1 so carry-out means "no borrow"
    always_comb begin
        b_eff   = op_sel_in ? ~src_in : src_in;
        sum_ext = {1'b0, acc_in} + {1'b0, b_eff} + (WIDTH+1)'(op_sel_in);
        shamt   = src_in[SHIFT_W-1:0];
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (unit_sel_in)
            3'b000: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (acc_in[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum_ext[WIDTH-1] != acc_in[WIDTH-1]);
            end
            3'b001:  sc_res = op_sel_in ? ~(acc_in & src_in) : (acc_in & src_in);
            3'b010:  sc_res = op_sel_in ? (acc_in >> shamt) : (acc_in << shamt);
            3'b011:  sc_res = src_in;
            3'b100:  sc_res = acc_in | src_in;
            3'b101:  sc_res = acc_in ^ src_in;
            3'b111:  sc_res = acc_in;
            default: sc_res = '0;
        endcase
    end

    // One shift-add step of the multiply, selected by the current multiplier bit
    always_comb begin
        addend    = mplier_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
        prod_step = prod_q + addend;
        mul_last  = (cnt_q == SHIFT_W'(WIDTH - 1));
    end

    // Next-state logic; flush always returns to IDLE and overrides both handshakes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (unit_sel_in == 3'b110) ? MUL : DONE;
            MUL:  if (mul_last) state_d = DONE;
            DONE: if (res_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_in) state_d = IDLE;
    end

    // Datapath updates: capture on accept, iterate while multiplying, otherwise hold
    always_comb begin
        res_d    = res_q;
        flags_d  = flags_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE && accept) begin
            if (unit_sel_in == 3'b110) begin
                mcand_d  = acc_in;
                mplier_d = src_in;
                prod_d   = '0;
                cnt_d    = '0;
            end else begin
                res_d   = sc_res;
                flags_d = {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
            end
        end else if (state_q == MUL && !flush_in) begin
            prod_d = prod_step;
            cnt_d  = cnt_q + SHIFT_W'(1);
            if (mul_last) begin
                cnt_d   = '0;
                res_d   = prod_step[WIDTH-1:0];
                flags_d = {prod_step[WIDTH-1], (prod_step[WIDTH-1:0] == '0),
                           (prod_step[2*WIDTH-1:WIDTH] != '0), 1'b0};
            end
        end
    end

    // Handshake and result outputs
    always_comb begin
        req_ready_out = (state_q == IDLE) && !flush_in && !rst_in;
        res_valid_out = (state_q == DONE);
        alu_res_out   = res_q;
        flags_out     = flags_q;
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks on an 8-bit seq_alu and a randomized regression
// on a 16-bit instance against a behavioural arithmetic model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        rv8 = 1'b0, rr8, resv8, resr8 = 1'b0, op8 = 1'b0;
    logic [2:0]  unit8 = 3'd0;
    logic [7:0]  acc8 = 8'd0, src8 = 8'd0, res8;
    logic [3:0]  flags8;

    logic        rv16 = 1'b0, rr16, resv16, resr16 = 1'b0, op16 = 1'b0;
    logic [2:0]  unit16 = 3'd0;
    logic [15:0] acc16 = 16'd0, src16 = 16'd0, res16;
    logic [3:0]  flags16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk_in(clk), .rst_in(rst), .flush_in(flush),
        .req_valid_in(rv8), .req_ready_out(rr8),
        .unit_sel_in(unit8), .op_sel_in(op8),
        .acc_in(acc8), .src_in(src8),
        .res_valid_out(resv8), .res_ready_in(resr8),
        .alu_res_out(res8), .flags_out(flags8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk_in(clk), .rst_in(rst), .flush_in(flush),
        .req_valid_in(rv16), .req_ready_out(rr16),
        .unit_sel_in(unit16), .op_sel_in(op16),
        .acc_in(acc16), .src_in(src16),
        .res_valid_out(resv16), .res_ready_in(resr16),
        .alu_res_out(res16), .flags_out(flags16)
    );

    // Hard stop in case anything stalls forever
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic getValid(input int w);
        return (w == 8) ? resv8 : resv16;
    endfunction

    function automatic logic getReady(input int w);
        return (w == 8) ? rr8 : rr16;
    endfunction

    function automatic logic [15:0] getRes(input int w);
        return (w == 8) ? {8'h00, res8} : res16;
    endfunction

    function automatic logic [3:0] getFlags(input int w);
        return (w == 8) ? flags8 : flags16;
    endfunction

    // Reference: plain integer arithmetic, returns {N,Z,C,V, result}
    function automatic logic [19:0] refModel(input int w, input logic [2:0] u, input logic o,
                                             input logic [15:0] a16, input logic [15:0] b16);
        longint one = 1;
        longint mask = (one << w) - 1;
        longint half = one << (w - 1);
        longint a = longint'(a16) & mask;
        longint b = longint'(b16) & mask;
        longint r = 0;
        longint full;
        longint sa, sb, sr;
        logic c = 1'b0, v = 1'b0, n, z;
        case (u)
            3'd0: begin
                sa = (a >= half) ? a - (one << w) : a;
                sb = (b >= half) ? b - (one << w) : b;
                sr = o ? sa - sb : sa + sb;
                full = o ? a + ((~b) & mask) + 1 : a + b;
                r = full & mask;
                c = ((full >> w) & 1) != 0;
                v = (sr > half - 1) || (sr < -half);
            end
            3'd1: r = o ? (~(a & b)) & mask : (a & b);
            3'd2: r = o ? (a >> (b % w)) : ((a << (b % w)) & mask);
            3'd3: r = b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin
                full = a * b;
                r = full & mask;
                c = (full >> w) != 0;
            end
            default: r = a;
        endcase
        n = ((r >> (w - 1)) & 1) != 0;
        z = (r == 0);
        return {n, z, c, v, r[15:0]};
    endfunction

    // Present one request, confirm it is accepted, then scramble operands to prove they are ignored
    task automatic applyStimulus(input int w, input logic [2:0] u, input logic o,
                                 input logic [15:0] a, input logic [15:0] b);
        if (w == 8) begin
            unit8 = u; op8 = o; acc8 = a[7:0]; src8 = b[7:0]; rv8 = 1'b1;
        end else begin
            unit16 = u; op16 = o; acc16 = a; src16 = b; rv16 = 1'b1;
        end
        #1;
        checkOutput("req_ready", 32'(getReady(w)), 32'd1);
        tick();
        rv8 = 1'b0; rv16 = 1'b0;
        acc8 = 8'($urandom); src8 = 8'($urandom);
        acc16 = 16'($urandom); src16 = 16'($urandom);
    endtask

    // Called at cycle 1 after accept; counts cycles until res_valid, bounded by maxc
    task automatic waitResult(input int w, input int maxc, output int lat);
        lat = 1;
        while (!getValid(w) && lat < maxc) begin
            tick();
            lat++;
        end
        checkOutput("res_valid", 32'(getValid(w)), 32'd1);
    endtask

    task automatic consume(input int w);
        if (w == 8) resr8 = 1'b1; else resr16 = 1'b1;
        tick();
        resr8 = 1'b0; resr16 = 1'b0;
        checkOutput("valid_drop", 32'(getValid(w)), 32'd0);
    endtask

    task automatic directedOp(input string tag, input logic [2:0] u, input logic o,
                              input logic [7:0] a, input logic [7:0] b, input int expLat,
                              input logic [7:0] expRes, input logic [3:0] expFlags);
        int lat;
        applyStimulus(8, u, o, {8'h00, a}, {8'h00, b});
        waitResult(8, expLat + 4, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_res"}, 32'(res8), 32'(expRes));
        checkOutput({tag, "_flags"}, 32'(flags8), 32'(expFlags));
        consume(8);
    endtask

    initial begin
        int lat;
        logic [2:0]  u;
        logic        o;
        logic [15:0] a, b;
        logic [19:0] exp;

        // Reset state
        tick();
        tick();
        checkOutput("rst_res", 32'(res8), 32'd0);
        checkOutput("rst_flags", 32'(flags8), 32'd0);
        checkOutput("rst_valid", 32'(resv8), 32'd0);
        checkOutput("rst_ready", 32'(rr8), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(rr8), 32'd1);

        // Directed 8-bit operations: {N,Z,C,V}
        directedOp("add_ff_01", 3'b000, 1'b0, 8'hFF, 8'h01, 1, 8'h00, 4'b0110);
        directedOp("sub_80_01", 3'b000, 1'b1, 8'h80, 8'h01, 1, 8'h7F, 4'b0011);
        directedOp("sub_00_01", 3'b000, 1'b1, 8'h00, 8'h01, 1, 8'hFF, 4'b1000);
        directedOp("mul_10_10", 3'b110, 1'b0, 8'h10, 8'h10, 9, 8'h00, 4'b0110);
        directedOp("shr_96_3",  3'b010, 1'b1, 8'h96, 8'h03, 1, 8'h12, 4'b0000);
        directedOp("shl_96_7",  3'b010, 1'b0, 8'h96, 8'h07, 1, 8'h00, 4'b0100);
        directedOp("shl_amt0",  3'b010, 1'b0, 8'h5A, 8'h08, 1, 8'h5A, 4'b0000);
        directedOp("nand_f0",   3'b001, 1'b1, 8'hF0, 8'h3C, 1, 8'hCF, 4'b1000);
        directedOp("or_a0_05",  3'b100, 1'b0, 8'hA0, 8'h05, 1, 8'hA5, 4'b1000);
        directedOp("pass_acc",  3'b111, 1'b0, 8'h00, 8'h77, 1, 8'h00, 4'b0100);

        // Multiply with per-cycle checks of ready/valid through the iteration
        applyStimulus(8, 3'b110, 1'b0, 16'h000F, 16'h0011);
        for (int c = 1; c <= 8; c++) begin
            checkOutput("mul_busy_valid", 32'(resv8), 32'd0);
            checkOutput("mul_busy_ready", 32'(rr8), 32'd0);
            tick();
        end
        checkOutput("mul_c9_valid", 32'(resv8), 32'd1);
        checkOutput("mul_c9_ready", 32'(rr8), 32'd0);
        checkOutput("mul_0f_11_res", 32'(res8), 32'h0FF);
        checkOutput("mul_0f_11_flags", 32'(flags8), 32'b1000);
        consume(8);

        // Backpressure: result held, new request waits until the cycle after transfer
        applyStimulus(8, 3'b000, 1'b0, 16'h0012, 16'h0034);
        unit8 = 3'b000; op8 = 1'b0; acc8 = 8'h01; src8 = 8'h02; rv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_valid", 32'(resv8), 32'd1);
            checkOutput("bp_res", 32'(res8), 32'h46);
            checkOutput("bp_flags", 32'(flags8), 32'd0);
            checkOutput("bp_ready", 32'(rr8), 32'd0);
            tick();
        end
        resr8 = 1'b1;
        #1;
        checkOutput("bp_xfer_ready", 32'(rr8), 32'd0);
        tick();
        resr8 = 1'b0;
        #1;
        checkOutput("bp_after_valid", 32'(resv8), 32'd0);
        checkOutput("bp_after_ready", 32'(rr8), 32'd1);
        tick();
        rv8 = 1'b0;
        checkOutput("bp_next_valid", 32'(resv8), 32'd1);
        checkOutput("bp_next_res", 32'(res8), 32'h03);
        consume(8);

        // Flush during multiply cycle 4, then an ADD on the following cycle
        applyStimulus(8, 3'b110, 1'b0, 16'h000F, 16'h0011);
        tick();
        tick();
        tick();
        flush = 1'b1;
        #1;
        checkOutput("flush_ready", 32'(rr8), 32'd0);
        tick();
        flush = 1'b0;
        checkOutput("flush_valid", 32'(resv8), 32'd0);
        checkOutput("flush_hold_res", 32'(res8), 32'h03);
        directedOp("add_after_flush", 3'b000, 1'b0, 8'h05, 8'h06, 1, 8'h0B, 4'b0000);

        // Same abort via reset: everything clears and the partial product never appears
        applyStimulus(8, 3'b110, 1'b0, 16'h000F, 16'h0011);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_res", 32'(res8), 32'd0);
        checkOutput("mrst_flags", 32'(flags8), 32'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("mrst_valid", 32'(resv8), 32'd0);
            tick();
        end
        checkOutput("mrst_ready", 32'(rr8), 32'd1);

        // 16-bit randomized regression against the reference model
        for (int i = 0; i < 60; i++) begin
            u = (i % 5 == 0) ? 3'b110 : 3'($urandom_range(0, 7));
            o = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
            exp = refModel(16, u, o, a, b);
            applyStimulus(16, u, o, a, b);
            waitResult(16, 40, lat);
            checkOutput("rnd_lat", 32'(lat), (u == 3'b110) ? 32'd17 : 32'd1);
            checkOutput("rnd_res", 32'(res16), 32'(exp[15:0]));
            checkOutput("rnd_flags", 32'(flags16), 32'(exp[19:16]));
            repeat ($urandom_range(0, 2)) begin
                tick();
                checkOutput("rnd_hold", 32'(res16), 32'(exp[15:0]));
            end
            consume(16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
